// File: rtl/aibndaux_mstr_detect_ctrl.sv
// Master-side aux sequencer: drives device_detect and its TX enable, debounces the
// slave's por level and reports readiness, por re-assertion events and a link timeout.
module aibndaux_mstr_detect_ctrl #(
  parameter int TXEN_LEAD  = 2,
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 8,
  parameter int TMO_CYCLES = 50000,
  parameter int TMO_W      = 16
) (
  input  logic       osc_clk,
  input  logic       dig_rstb,
  input  logic       i_en,
  input  logic       i_por_async,
  output logic       o_device_detect,
  output logic       o_detect_txen,
  output logic       o_remote_ready,
  output logic       o_por_event,
  output logic       o_timeout,
  output logic [2:0] o_state,
  output logic [7:0] o_por_event_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TXEN     = 3'd1,
    WAIT_REL = 3'd2,
    READY    = 3'd3,
    TIMEOUT  = 3'd4
  } state_t;

  localparam int                LEAD_W    = (TXEN_LEAD > 1) ? $clog2(TXEN_LEAD) : 1;
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(TXEN_LEAD - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [7:0]        CNT_MAX   = 8'hFF;

  state_t            state;
  logic              por_meta;
  logic              por_sync;
  logic [LEAD_W-1:0] lead_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              deb_target;
  logic              deb_match;
  logic              deb_accept;
  logic [DEB_W-1:0]  deb_next;

  assign o_state = state;

  // Two-flop synchronizer; reset value 1 means the remote is assumed held in reset.
  always_ff @(posedge osc_clk) begin
    if (!dig_rstb) begin
      por_meta <= 1'b1;
      por_sync <= 1'b1;
    end else begin
      por_meta <= i_por_async;
      por_sync <= por_meta;
    end
  end

  // Debounce compare: release (0) is awaited in WAIT_REL, re-assertion (1) in READY.
  always_comb begin
    deb_target = 1'b0;
    if (state == READY) begin
      deb_target = 1'b1;
    end else begin
      deb_target = 1'b0;
    end
    deb_match  = (por_sync == deb_target);
    deb_accept = deb_match && (deb_cnt == DEB_LAST);
    if (deb_match) begin
      deb_next = deb_cnt + DEB_W'(1);
    end else begin
      deb_next = {DEB_W{1'b0}};
    end
  end

  // Sequencer FSM with registered pad controls, status flags and event counter.
  always_ff @(posedge osc_clk) begin
    if (!dig_rstb) begin
      state           <= IDLE;
      lead_cnt        <= {LEAD_W{1'b0}};
      deb_cnt         <= {DEB_W{1'b0}};
      tmo_cnt         <= {TMO_W{1'b0}};
      o_device_detect <= 1'b0;
      o_detect_txen   <= 1'b0;
      o_remote_ready  <= 1'b0;
      o_por_event     <= 1'b0;
      o_timeout       <= 1'b0;
      o_por_event_cnt <= 8'd0;
    end else begin
      o_por_event <= 1'b0;
      if (!i_en) begin
        // Data and driver enable drop together; the event count survives a disable.
        state           <= IDLE;
        lead_cnt        <= {LEAD_W{1'b0}};
        deb_cnt         <= {DEB_W{1'b0}};
        tmo_cnt         <= {TMO_W{1'b0}};
        o_device_detect <= 1'b0;
        o_detect_txen   <= 1'b0;
        o_remote_ready  <= 1'b0;
        o_timeout       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state           <= TXEN;
            lead_cnt        <= {LEAD_W{1'b0}};
            deb_cnt         <= {DEB_W{1'b0}};
            tmo_cnt         <= {TMO_W{1'b0}};
            o_detect_txen   <= 1'b1;
            o_device_detect <= 1'b0;
            o_remote_ready  <= 1'b0;
            o_timeout       <= 1'b0;
          end
          TXEN: begin
            if (lead_cnt == LEAD_LAST) begin
              state           <= WAIT_REL;
              lead_cnt        <= {LEAD_W{1'b0}};
              o_device_detect <= 1'b1;
            end else begin
              lead_cnt <= lead_cnt + LEAD_W'(1);
            end
          end
          WAIT_REL: begin
            // A release completing on the timeout edge still wins.
            if (deb_accept) begin
              state          <= READY;
              deb_cnt        <= {DEB_W{1'b0}};
              tmo_cnt        <= {TMO_W{1'b0}};
              o_remote_ready <= 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
              state     <= TIMEOUT;
              deb_cnt   <= {DEB_W{1'b0}};
              tmo_cnt   <= {TMO_W{1'b0}};
              o_timeout <= 1'b1;
            end else begin
              deb_cnt <= deb_next;
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          READY: begin
            if (deb_accept) begin
              state          <= WAIT_REL;
              deb_cnt        <= {DEB_W{1'b0}};
              tmo_cnt        <= {TMO_W{1'b0}};
              o_remote_ready <= 1'b0;
              o_por_event    <= 1'b1;
              if (o_por_event_cnt != CNT_MAX) begin
                o_por_event_cnt <= o_por_event_cnt + 8'd1;
              end else begin
                o_por_event_cnt <= CNT_MAX;
              end
            end else begin
              deb_cnt <= deb_next;
            end
          end
          TIMEOUT: begin
            deb_cnt <= {DEB_W{1'b0}};
            tmo_cnt <= {TMO_W{1'b0}};
          end
          default: begin
            state           <= IDLE;
            lead_cnt        <= {LEAD_W{1'b0}};
            deb_cnt         <= {DEB_W{1'b0}};
            tmo_cnt         <= {TMO_W{1'b0}};
            o_device_detect <= 1'b0;
            o_detect_txen   <= 1'b0;
            o_remote_ready  <= 1'b0;
            o_timeout       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/aibndaux_mstr_detect_ctrl.md
Name: aibndaux_mstr_detect_ctrl

Overview:
Master-side aux-channel sequencer, the counterpart of the slave aux pad block. The slave detects device_detect and drives its power-on-reset (por) back across the aux pads. This block drives the device_detect pad data and its TX-driver enable, synchronizes and debounces the slave's por level, and reports remote readiness, por re-assertion events and a link timeout. It sits between the master aux pad buffers and the master reset/config logic.

Parameters:
TXEN_LEAD, 2, cycles o_detect_txen leads o_device_detect high (driver enabled before data toggles); >=1
DEB_CYCLES, 16, consecutive synchronized samples required to accept a por level change; >=2
DEB_W, 8, debounce counter width; 2^DEB_W > DEB_CYCLES
TMO_CYCLES, 50000, cycles allowed in WAIT_REL for por release before timeout
TMO_W, 16, timeout counter width; 2^TMO_W > TMO_CYCLES

Ports:
osc_clk  input  1  aux oscillator clock; all logic on rising edge
dig_rstb  input  1  synchronous, active-low reset
i_en  input  1  link bring-up enable (level)
i_por_async  input  1  slave por from aux pad receiver, asynchronous, 1 = remote in reset
o_device_detect  output  1  data to device_detect pad transmitter
o_detect_txen  output  1  device_detect pad TX driver enable
o_remote_ready  output  1  remote por released and stable
o_por_event  output  1  one-cycle pulse on debounced por re-assertion while READY
o_timeout  output  1  por not released within TMO_CYCLES; held until i_en=0
o_state  output  3  current FSM encoding
o_por_event_cnt  output  8  saturating count of por events

Behaviour:
- Reset (dig_rstb=0 at an edge): state IDLE; all outputs 0 except sync flops, which load 1 (remote assumed in reset); counters 0. Reset applied mid-operation aborts immediately. No asynchronous reset path exists.
- Sync: 2-flop synchronizer on i_por_async; por_sync = second flop. No logic uses i_por_async directly.
- Debounce: deb_cnt increments when por_sync == target, else clears; it also clears on every state change. Target is 0 in WAIT_REL and 1 in READY. Accept when por_sync == target and deb_cnt == DEB_CYCLES-1. Glitches shorter than DEB_CYCLES are ignored.
- FSM and encodings (all outputs registered):
  - IDLE(0): txen=0, detect=0, ready=0. i_en=1 -> TXEN.
  - TXEN(1): txen=1, detect=0; after TXEN_LEAD cycles in state -> WAIT_REL.
  - WAIT_REL(2): txen=1, detect=1; tmo_cnt increments each cycle.
    - por release accepted -> READY.
    - else tmo_cnt == TMO_CYCLES-1 -> TIMEOUT.
    - If both occur in the same cycle, READY wins.
  - READY(3): ready=1, txen=1, detect=1. Debounced por=1 accepted -> WAIT_REL:
    - ready=0, o_por_event pulses 1 cycle, cnt += 1 (saturates at 255), tmo_cnt cleared.
  - TIMEOUT(4): timeout=1, txen=1, detect=1, ready=0; remains here until i_en=0.
- i_en=0 in any state: next edge -> IDLE. txen, detect, ready and timeout go 0 and the counters clear, except o_por_event_cnt, which clears only on reset.
- Latency: first edge sampling i_por_async=0 (in WAIT_REL, steady input) -> o_remote_ready=1 after DEB_CYCLES+2 edges.
- Timing: o_detect_txen never deasserts before o_device_detect. Both fall on the same edge when leaving to IDLE.
- Unused encodings 5-7 -> IDLE next cycle.

Test Plan:
- Reset/bring-up (defaults, por held 1): dig_rstb=0 -> all outputs 0, o_state=0. Then i_en=1 -> txen=1 at edge 1, detect=1 at edge 1+TXEN_LEAD=3, o_state=2.
- Release: i_por_async=0 steady from WAIT_REL -> o_remote_ready=1 exactly 18 edges after the first edge sampling 0; o_state=3.
- Glitch rejection: in READY, por=1 pulse of 10 cycles -> ready stays 1, no event. por=1 for 20 cycles -> ready=0, o_por_event pulses once, o_por_event_cnt=1, o_state=2.
- Timeout (TMO_CYCLES=100): por held 1 -> o_timeout=1 and o_state=4 on edge 100 of WAIT_REL. Later por=0 -> stays in TIMEOUT. Then i_en=0 -> IDLE, timeout=0.
- Saturation / tie: 300 debounced por events -> cnt=255. Debounce completes on the same edge as the timeout limit -> READY, o_timeout stays 0.
- Mid-operation reset/disable: dig_rstb=0 while READY -> next edge all outputs 0 and cnt=0. i_en=0 while READY with cnt=3 -> IDLE with cnt=3 retained.
